if_fetch_pc_ctrl: RTL
=====================

// Module: if_fetch_pc_ctrl
// PURPOSE
//  Fetch-PC sequencer at the head of IF. Issues one 4-instruction fetch group per accepted cycle,
//  and consumes the four-to-one branch selection result (take / dest / needDelaySlot) for that group.
//  Computes the next fetch PC and handles a predicted branch in lane 3, whose delay slot lies in the
//  next group. A backend redirect (mispredict / exception / eret) overrides all prediction state.
// PARAMETERS
//  RESET_PC     32'hbfc0_0000  fetch PC loaded on reset
//  GROUP_BYTES  16             bytes per fetch group (4 insts x 4 B); fixed, used for sequential PC
// PORTS
//  clk              in   1   single clock, all state on posedge
//  rst              in   1   synchronous, active-high reset
//  fetchReady_i     in   1   ICache/IF accepts the current request this cycle
//  fetchValid_o     out  1   fetchPC_o / fetchEnable_o are a valid request
//  fetchPC_o        out  32  fetch address (word aligned, may be mid-group)
//  fetchEnable_o    out  4   lane enables for this group (originEnable of the selector)
//  predTake_i       in   1   selector validTake for the current group
//  predDest_i       in   32  selector validDest (target if taken, else next group PC)
//  predNeedDs_i     in   1   selector needDelaySlot (first taken branch is lane 3)
//  redirectValid_i  in   1   backend flush; highest priority
//  redirectPC_i     in   32  flush target
//  dsPending_o      out  1   current request is a delay-slot-only group
// BEHAVIOUR
//  Reset: fetchValid_o=0, fetchPC_o=RESET_PC, fetchEnable_o=4'b0000, dsPending_o=0, state=NORMAL,
//   held target=0. First cycle after reset release: fetchValid_o=1, PC=RESET_PC.
//  Accept = fetchValid_o & fetchReady_i. All state advances only on accept or on redirect.
//  With no accept and no redirect, every output and register holds.
//  seqPC = {fetchPC_o[31:4]+28'd1, 4'b0000}; wraps 32'hffff_fff0 -> 0 (no overflow flag).
//  fetchEnable_o in NORMAL: lanes >= fetchPC_o[3:2] set (00->1111, 01->1110, 10->1100, 11->1000).
//  fetchEnable_o in DS_WAIT: 4'b0001 (delay-slot lane only; fetchPC_o is group-aligned).
//  States:
//   NORMAL, accept, predNeedDs_i=1 -> DS_WAIT; held target<=predDest_i; PC<=seqPC.
//   NORMAL, accept, predTake_i=1, predNeedDs_i=0 -> NORMAL; PC<=predDest_i.
//   NORMAL, accept, no take -> NORMAL; PC<=seqPC (equals predDest_i; use seqPC).
//   DS_WAIT, accept -> NORMAL; PC<=held target. Prediction inputs are ignored in this state.
//  dsPending_o = (state==DS_WAIT).
//  Redirect: on redirectValid_i, next cycle PC=redirectPC_i, state=NORMAL, held target cleared,
//   fetchValid_o=1. Applies regardless of fetchReady_i or a simultaneous accept; the accepted
//   request's prediction is discarded. Redirect in DS_WAIT cancels the pending target.
//  Redirect asserted in the same cycle as rst: rst wins.
//  predNeedDs_i=1 implies predTake_i=1. If predNeedDs_i=1 with predTake_i=0, treat it as a take.
//  Latency: a prediction influences fetchPC_o exactly 1 cycle after the accept edge.
//  Redirect->fetchPC_o also takes 1 cycle. There is no combinational path from inputs to outputs.
// STRUCTURE
//  Shared defines (MyDefines.v): SINGLE_WORD, INST_NUM, IF_PC_NORMAL/IF_PC_DS_WAIT state
//   encodings (1-bit), RESET_PC constant.
//  Sub-module if_lane_mask: pure combinational, pc[3:2] + dsPending -> 4-bit enable. It is reused
//   by the decode-side validity check.
//  Remaining logic: state reg, PC reg, held-target reg, next-PC mux with priority
//   rst > redirect > accept > hold.
// TESTING
//  1 Reset: rst=1 two cycles -> valid=0, PC=bfc00000, en=0000; release -> valid=1, PC=bfc00000, en=1111.
//  2 Sequential+stall: PC=bfc00008, ready=1, no take -> next PC=bfc00010, en=1111; ready=0 3 cycles
//    -> PC/en unchanged.
//  3 Take lane 1: PC=80001000, take=1, dest=80002004, ds=0 -> next PC=80002004, en=1110, dsPending=0.
//  4 Lane-3 branch: PC=80001000, take=1, ds=1, dest=80003000 -> PC=80001010, en=0001, dsPending=1;
//    ready=0 2 cycles -> holds; accept -> PC=80003000, en=1111, dsPending=0.
//  5 Redirect in DS_WAIT: dsPending=1 (target 80003000), redirect=1 pc=bfc00380 -> next PC=bfc00380,
//    dsPending=0; next accept -> seq bfc00390 (no 80003000).
//  6 Redirect+accept+take same cycle: redirect pc=80000180, take dest=80005000 -> PC=80000180;
//    wrap case PC=fffffff0 no take -> PC=00000000.

Source files
------------

// File: rtl/if_fetch_pc_ctrl_pkg.sv
// rtl/if_fetch_pc_ctrl_pkg.sv - shared constants, state encoding and helpers for the IF fetch-PC sequencer
package if_fetch_pc_ctrl_pkg;

   localparam int unsigned INST_NUM    = 4;
   localparam logic [31:0] IF_RESET_PC = 32'hbfc0_0000;

   typedef enum logic {
      IF_PC_NORMAL  = 1'b0,
      IF_PC_DS_WAIT = 1'b1
   } if_pc_state_e;

   // Start of the following fetch group; wraps silently at the top of the address space.
   function automatic logic [31:0] seq_group_pc(input logic [31:0] pc);
      return {pc[31:4] + 28'd1, 4'b0000};
   endfunction

endpackage

// File: rtl/if_fetch_pc_ctrl_if.sv
// rtl/if_fetch_pc_ctrl_if.sv - fetch request, branch-selector result and backend redirect bundle
interface if_fetch_pc_ctrl_if;
   import if_fetch_pc_ctrl_pkg::*;

   logic                fetchReady_i;
   logic                fetchValid_o;
   logic [31:0]         fetchPC_o;
   logic [INST_NUM-1:0] fetchEnable_o;
   logic                predTake_i;
   logic [31:0]         predDest_i;
   logic                predNeedDs_i;
   logic                redirectValid_i;
   logic [31:0]         redirectPC_i;
   logic                dsPending_o;

   modport master (
      input  fetchReady_i, predTake_i, predDest_i, predNeedDs_i, redirectValid_i, redirectPC_i,
      output fetchValid_o, fetchPC_o, fetchEnable_o, dsPending_o
   );

   modport slave (
      output fetchReady_i, predTake_i, predDest_i, predNeedDs_i, redirectValid_i, redirectPC_i,
      input  fetchValid_o, fetchPC_o, fetchEnable_o, dsPending_o
   );

endinterface

// File: rtl/if_fetch_pc_ctrl_lane_mask.sv
// rtl/if_fetch_pc_ctrl_lane_mask.sv - lane enables from word offset within the group
// Shared with the decode-side validity check, so it stays purely combinational.
module if_fetch_pc_ctrl_lane_mask
   import if_fetch_pc_ctrl_pkg::*;
(
   input  logic [1:0]          lane_i,
   input  logic                dsPending_i,
   output logic [INST_NUM-1:0] enable_o
);

   always_comb begin
      enable_o = '0;
      if (dsPending_i) begin
         enable_o = {{(INST_NUM-1){1'b0}}, 1'b1};
      end else begin
         for (int k = 0; k < INST_NUM; k++) begin
            enable_o[k] = (k >= int'(lane_i));
         end
      end
   end

endmodule

// File: rtl/if_fetch_pc_ctrl.sv
// rtl/if_fetch_pc_ctrl.sv - fetch-PC sequencer: next-PC selection, lane-3 delay-slot handling, redirect
module if_fetch_pc_ctrl
   import if_fetch_pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IF_RESET_PC
)(
   input  logic                clk,
   input  logic                rst,
   if_fetch_pc_ctrl_if.master  bus
);

   if_pc_state_e        state_q, state_d;
   logic [31:0]         pc_q, pc_d;
   logic [31:0]         tgt_q, tgt_d;
   logic                valid_q, valid_d;
   logic                accept;
   logic                take;
   logic [INST_NUM-1:0] lane_en;

   assign accept = valid_q & bus.fetchReady_i;
   // A delay-slot request without a take is still a taken branch.
   assign take   = bus.predTake_i | bus.predNeedDs_i;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      valid_d = 1'b1;
      if (bus.redirectValid_i) begin
         state_d = IF_PC_NORMAL;
         pc_d    = bus.redirectPC_i;
         tgt_d   = '0;
      end else if (accept) begin
         unique case (state_q)
            IF_PC_DS_WAIT: begin
               state_d = IF_PC_NORMAL;
               pc_d    = tgt_q;
            end
            default: begin
               if (bus.predNeedDs_i) begin
                  state_d = IF_PC_DS_WAIT;
                  tgt_d   = bus.predDest_i;
                  pc_d    = seq_group_pc(pc_q);
               end else if (take) begin
                  pc_d    = bus.predDest_i;
               end else begin
                  pc_d    = seq_group_pc(pc_q);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IF_PC_NORMAL;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         valid_q <= valid_d;
      end
   end

   if_fetch_pc_ctrl_lane_mask u_lane_mask (
      .lane_i      (pc_q[3:2]),
      .dsPending_i (state_q == IF_PC_DS_WAIT),
      .enable_o    (lane_en)
   );

   assign bus.fetchValid_o  = valid_q;
   assign bus.fetchPC_o     = pc_q;
   assign bus.fetchEnable_o = valid_q ? lane_en : '0;
   assign bus.dsPending_o   = (state_q == IF_PC_DS_WAIT);

endmodule
